div_mul_sequencer: RTL and testbench

DIV_MUL_SEQUENCER -- requirements
Module: div_mul_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 20 ++
 rtl/reg_sel_decoder.sv | 13 +
 rtl/div_mul_sequencer.sv | 159 +++++++++++++++
 tb/tb_div_mul_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the MUL/DIV instruction sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT4w, StT5, StT6, StIll
  } state_e;

  localparam logic [4:0]  OP_MUL  = 5'b01000;
  localparam logic [4:0]  OP_DIV  = 5'b01001;
  localparam logic [11:0] ALU_MUL = 12'b0000_0000_0100;
  localparam logic [11:0] ALU_DIV = 12'b0000_0000_1000;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;
  localparam int unsigned RB_HI  = 22;
  localparam int unsigned RB_LO  = 19;
  localparam int unsigned RC_HI  = 18;
  localparam int unsigned RC_LO  = 15;

endpackage

// File: rtl/reg_sel_decoder.sv
// 4-to-16 one-hot register select with enable; all zero when disabled.
module reg_sel_decoder (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/div_mul_sequencer.sv
// Control sequencer for fetch and execute of MUL/DIV instructions on a single-bus datapath.
module div_mul_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  input  logic        alu_done,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        MDRRead,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rout,
  output logic [11:0] ALUControl,
  output logic        alu_start,
  output logic        busy,
  output logic        illegal
);

  state_e     state_q, state_d;
  logic       t1_first_q;
  logic       done_q;
  logic       illegal_q, illegal_d;
  logic [4:0] opcode;
  logic [3:0] rb, rc;
  logic       rout_en;
  logic [3:0] rout_sel;
  logic       alu_go;
  logic       unused_ir;

  assign opcode    = ir[OPC_HI:OPC_LO];
  assign rb        = ir[RB_HI:RB_LO];
  assign rc        = ir[RC_HI:RC_LO];
  assign unused_ir = ^{ir[26:23], ir[14:0]};

  // An alu_done seen during T4 is remembered so the first T4W cycle can honour it.
  assign alu_go = alu_done | done_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= StIdle;
      t1_first_q <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      t1_first_q <= (state_q == StT0);
      done_q     <= (state_q == StT4) & alu_done;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: if (run) state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   if (mem_ready) state_d = StT2;
      StT2: begin
        if (opcode == OP_MUL || opcode == OP_DIV) begin
          state_d = StT3;
        end else begin
          state_d   = StIll;
          illegal_d = 1'b1;
        end
      end
      StT3:   state_d = StT4;
      StT4:   state_d = StT4w;
      StT4w:  if (alu_go) state_d = StT5;
      StT5:   state_d = StT6;
      StT6:   state_d = run ? StT0 : StIdle;
      StIll:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    PCin       = 1'b0;
    MDRRead    = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    alu_start  = 1'b0;
    ALUControl = '0;
    rout_en    = 1'b0;
    rout_sel   = rc;
    case (state_q)
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1;
        PCin    = t1_first_q;
        MDRRead = 1'b1;
        MDRin   = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        rout_en  = 1'b1;
        rout_sel = rb;
        Yin      = 1'b1;
      end
      StT4, StT4w: begin
        rout_en   = 1'b1;
        alu_start = (state_q == StT4);
        Zin       = (state_q == StT4w) & alu_go;
        if (opcode == OP_DIV)      ALUControl = ALU_DIV;
        else if (opcode == OP_MUL) ALUControl = ALU_MUL;
      end
      StT5: begin
        Zlowout = 1'b1;
        LOin    = 1'b1;
      end
      StT6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign illegal = illegal_q;

  reg_sel_decoder u_reg_sel_decoder (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_div_mul_sequencer.sv
// Directed-vector bench for div_mul_sequencer; per-cycle control words checked against hand tables.
module tb_div_mul_sequencer;

  logic        clk = 1'b0;
  logic        clr, run, mem_ready, alu_done;
  logic [31:0] ir;
  logic        PCout, MARin, IncPC, PCin, MDRRead, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [15:0] Rout;
  logic [11:0] ALUControl;
  logic        alu_start, busy, illegal;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        ill_exp  = 1'b0;

  // Observed control word, MSB first: PCout..HIin, alu_start, busy (illegal checked separately).
  localparam logic [15:0] C_PCOUT = 16'h8000, C_MARIN = 16'h4000, C_INCPC = 16'h2000;
  localparam logic [15:0] C_PCIN  = 16'h1000, C_MDRRD = 16'h0800, C_MDRIN = 16'h0400;
  localparam logic [15:0] C_MDROUT = 16'h0200, C_IRIN = 16'h0100, C_YIN = 16'h0080;
  localparam logic [15:0] C_ZIN   = 16'h0040, C_ZLO = 16'h0020, C_ZHI = 16'h0010;
  localparam logic [15:0] C_LOIN  = 16'h0008, C_HIIN = 16'h0004, C_START = 16'h0002;
  localparam logic [15:0] C_BUSY  = 16'h0001;

  localparam logic [15:0] E_T0  = C_PCOUT | C_MARIN | C_INCPC | C_ZIN | C_BUSY;
  localparam logic [15:0] E_T1F = C_ZLO | C_PCIN | C_MDRRD | C_MDRIN | C_BUSY;
  localparam logic [15:0] E_T1  = C_ZLO | C_MDRRD | C_MDRIN | C_BUSY;
  localparam logic [15:0] E_T2  = C_MDROUT | C_IRIN | C_BUSY;
  localparam logic [15:0] E_T3  = C_YIN | C_BUSY;
  localparam logic [15:0] E_T4  = C_START | C_BUSY;
  localparam logic [15:0] E_T5  = C_ZLO | C_LOIN | C_BUSY;
  localparam logic [15:0] E_T6  = C_ZHI | C_HIIN | C_BUSY;

  localparam logic [31:0] IR_DIV = 32'h4A92_0000;  // Rb=2, Rc=4
  localparam logic [31:0] IR_MUL = 32'h403B_8000;  // Rb=Rc=7
  localparam logic [31:0] IR_BAD = 32'h1800_0000;  // opcode 00011

  div_mul_sequencer dut (
    .clk        (clk),
    .clr        (clr),
    .run        (run),
    .mem_ready  (mem_ready),
    .ir         (ir),
    .alu_done   (alu_done),
    .PCout      (PCout),
    .MARin      (MARin),
    .IncPC      (IncPC),
    .PCin       (PCin),
    .MDRRead    (MDRRead),
    .MDRin      (MDRin),
    .MDRout     (MDRout),
    .IRin       (IRin),
    .Yin        (Yin),
    .Zin        (Zin),
    .Zlowout    (Zlowout),
    .Zhighout   (Zhighout),
    .LOin       (LOin),
    .HIin       (HIin),
    .Rout       (Rout),
    .ALUControl (ALUControl),
    .alu_start  (alu_start),
    .busy       (busy),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ctrl_word();
    return {PCout, MARin, IncPC, PCin, MDRRead, MDRin, MDRout, IRin,
            Yin, Zin, Zlowout, Zhighout, LOin, HIin, alu_start, busy};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One cycle: drive handshakes after the falling edge, then compare the settled outputs.
  task automatic cyc(input string tag, input logic mr, input logic ad,
                     input logic [15:0] e_ctrl, input logic [15:0] e_rout,
                     input logic [11:0] e_alu);
    @(negedge clk);
    mem_ready = mr;
    alu_done  = ad;
    #1;
    check_eq({tag, ".ctrl"}, {16'h0, ctrl_word()}, {16'h0, e_ctrl});
    check_eq({tag, ".rout"}, {16'h0, Rout}, {16'h0, e_rout});
    check_eq({tag, ".alu"}, {20'h0, ALUControl}, {20'h0, e_alu});
    check_eq({tag, ".ill"}, {31'h0, illegal}, {31'h0, ill_exp});
  endtask

  // Bus exclusivity every cycle while out of reset.
  always @(negedge clk) begin
    #2;
    if (clr === 1'b1)
      check_eq("bus_excl",
               ($countones(Rout) + PCout + MDRout + Zlowout + Zhighout) > 1, 0);
  end

  initial begin
    clr = 1'b0; run = 1'b0; mem_ready = 1'b0; alu_done = 1'b0; ir = IR_DIV;
    @(negedge clk); #1;
    check_eq("rst.ctrl", {16'h0, ctrl_word()}, 0);
    check_eq("rst.rout", {16'h0, Rout}, 0);
    check_eq("rst.ill", {31'h0, illegal}, 0);
    @(negedge clk);
    clr = 1'b1; run = 1'b1;

    // DIV with one memory wait and alu_done five cycles after alu_start.
    cyc("div.t0",  0, 0, E_T0,  16'h0000, 12'h000);
    cyc("div.t1a", 0, 0, E_T1F, 16'h0000, 12'h000);
    cyc("div.t1b", 1, 0, E_T1,  16'h0000, 12'h000);
    cyc("div.t2",  0, 0, E_T2,  16'h0000, 12'h000);
    cyc("div.t3",  0, 0, E_T3,  16'h0004, 12'h000);
    cyc("div.t4",  0, 0, E_T4,  16'h0010, 12'h008);
    for (int i = 0; i < 4; i++)
      cyc("div.t4w", 0, 0, C_BUSY, 16'h0010, 12'h008);
    cyc("div.t4wd", 0, 1, C_ZIN | C_BUSY, 16'h0010, 12'h008);
    cyc("div.t5",  0, 0, E_T5,  16'h0000, 12'h000);
    cyc("div.t6",  0, 0, E_T6,  16'h0000, 12'h000);

    // MUL, Rb=Rc=7, zero-wait handshakes; alu_done in T4 must be latched.
    @(negedge clk);
    ir = IR_MUL; mem_ready = 1'b0; alu_done = 1'b0; #1;
    check_eq("mul.t0.ctrl", {16'h0, ctrl_word()}, {16'h0, E_T0});
    cyc("mul.t1",  1, 0, E_T1F, 16'h0000, 12'h000);
    cyc("mul.t2",  0, 0, E_T2,  16'h0000, 12'h000);
    cyc("mul.t3",  0, 0, E_T3,  16'h0080, 12'h000);
    cyc("mul.t4",  0, 1, E_T4,  16'h0080, 12'h004);
    cyc("mul.t4w", 0, 0, C_ZIN | C_BUSY, 16'h0080, 12'h004);
    cyc("mul.t5",  0, 0, E_T5,  16'h0000, 12'h000);
    run = 1'b0;
    cyc("mul.t6",  0, 0, E_T6,  16'h0000, 12'h000);
    cyc("mul.idle", 0, 0, 16'h0000, 16'h0000, 12'h000);

    // Unsupported opcode.
    ir = IR_BAD; run = 1'b1;
    cyc("ill.t0",  0, 0, E_T0,  16'h0000, 12'h000);
    run = 1'b0;
    cyc("ill.t1",  1, 0, E_T1F, 16'h0000, 12'h000);
    cyc("ill.t2",  0, 0, E_T2,  16'h0000, 12'h000);
    ill_exp = 1'b1;
    cyc("ill.ill", 0, 0, C_BUSY, 16'h0000, 12'h000);
    cyc("ill.idle", 0, 0, 16'h0000, 16'h0000, 12'h000);
    cyc("ill.hold", 0, 0, 16'h0000, 16'h0000, 12'h000);

    // Asynchronous clear while waiting in T4W.
    ir = IR_DIV; run = 1'b1;
    cyc("clr.t0",  0, 0, E_T0,  16'h0000, 12'h000);
    cyc("clr.t1",  1, 0, E_T1F, 16'h0000, 12'h000);
    cyc("clr.t2",  0, 0, E_T2,  16'h0000, 12'h000);
    cyc("clr.t3",  0, 0, E_T3,  16'h0004, 12'h000);
    cyc("clr.t4",  0, 0, E_T4,  16'h0010, 12'h008);
    cyc("clr.t4w", 0, 0, C_BUSY, 16'h0010, 12'h008);
    #1 clr = 1'b0;
    #1;
    check_eq("clr.async.ctrl", {16'h0, ctrl_word()}, 0);
    check_eq("clr.async.rout", {16'h0, Rout}, 0);
    check_eq("clr.async.alu", {20'h0, ALUControl}, 0);
    check_eq("clr.async.ill", {31'h0, illegal}, 0);
    ill_exp = 1'b0;
    @(negedge clk);
    clr = 1'b1;

    // Restart after clear, then drop run in T3: instruction must still complete.
    cyc("run.t0",  0, 0, E_T0,  16'h0000, 12'h000);
    cyc("run.t1",  1, 0, E_T1F, 16'h0000, 12'h000);
    cyc("run.t2",  0, 0, E_T2,  16'h0000, 12'h000);
    run = 1'b0;
    cyc("run.t3",  0, 0, E_T3,  16'h0004, 12'h000);
    cyc("run.t4",  0, 0, E_T4,  16'h0010, 12'h008);
    cyc("run.t4w", 0, 1, C_ZIN | C_BUSY, 16'h0010, 12'h008);
    cyc("run.t5",  0, 0, E_T5,  16'h0000, 12'h000);
    cyc("run.t6",  0, 0, E_T6,  16'h0000, 12'h000);
    cyc("run.idle", 0, 0, 16'h0000, 16'h0000, 12'h000);
    cyc("run.idle2", 0, 0, 16'h0000, 16'h0000, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
